// File: rtl/qspi_flash_pkg.sv
// Shared types and constants for the Avalon QSPI flash reader.
package qspi_flash_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    DONE,
    CS_HIGH
  } state_e;

  localparam logic [7:0]  CMD_QUAD_OUT_READ = 8'h6B;
  localparam int unsigned CMD_BITS          = 8;
  localparam int unsigned ADDR_BITS         = 24;
  localparam int unsigned DATA_NIBBLES      = 8;
  localparam int unsigned CNT_W             = 8;

  // States during which nCS is low and SCK runs
  function automatic logic in_xfer(input state_e s);
    return (s == CMD) || (s == ADDR) || (s == DUMMY) || (s == DATA);
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/qspi_shift_engine.sv
// SCK divider, serial command/address shifter and quad nibble capture.
module qspi_shift_engine
  import qspi_flash_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        active_i,
  input  logic        load_i,
  input  logic [31:0] load_val_i,
  input  logic        capture_i,
  input  logic        oe0_d_i,
  input  logic        oe_hi_d_i,
  input  logic [3:0]  io_i,
  output logic        sck_o,
  output logic [3:0]  io_out_o,
  output logic [3:0]  io_oe_o,
  output logic [31:0] word_o
);

  logic        sck_q, sck_d;
  logic [31:0] sr_q, sr_d;
  logic [31:0] din_q, din_d;
  logic        oe0_q, oe_hi_q;

  // Shifts and captures happen on the sys edge that ends phase H
  always_comb begin
    sck_d = active_i ? ~sck_q : 1'b0;
    sr_d  = sr_q;
    din_d = din_q;
    if (load_i) begin
      sr_d = load_val_i;
    end else if (active_i && sck_q) begin
      sr_d = {sr_q[30:0], 1'b0};
    end
    if (capture_i && sck_q) begin
      din_d = {din_q[27:0], io_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sck_q   <= 1'b0;
      sr_q    <= '0;
      din_q   <= '0;
      oe0_q   <= 1'b0;
      oe_hi_q <= 1'b1;
    end else begin
      sck_q   <= sck_d;
      sr_q    <= sr_d;
      din_q   <= din_d;
      oe0_q   <= oe0_d_i;
      oe_hi_q <= oe_hi_d_i;
    end
  end

  assign sck_o    = sck_q;
  assign io_out_o = {2'b11, 1'b0, sr_q[31]};
  assign io_oe_o  = {oe_hi_q, oe_hi_q, 1'b0, oe0_q};
  // First byte received lands in the low byte of the bus word
  assign word_o   = bswap32(din_q);

endmodule

// File: rtl/av_qspi_flash_reader.sv
// Read-only Avalon slave that serves word reads with Quad Output Fast Read
// transactions on a QSPI flash.
module av_qspi_flash_reader
  import qspi_flash_pkg::*;
#(
  parameter int unsigned NUM_PERIPH_SEL_BITS = 1,
  parameter int unsigned PERIPH_SEL_VAL      = 0,
  parameter logic [7:0]  READ_CMD            = CMD_QUAD_OUT_READ,
  parameter int unsigned DUMMY_CYCLES        = 8,
  parameter int unsigned CS_HIGH_CYCLES      = 2
) (
  input  logic        i_Clk,
  input  logic        i_nReset,
  input  logic [29:0] i_AV_Addr,
  input  logic [3:0]  i_AV_ByteEn,
  input  logic        i_AV_Read,
  input  logic        i_AV_Write,
  output logic [31:0] o_AV_ReadData,
  input  logic [31:0] i_AV_WriteData,
  output logic        o_AV_WaitRequest,
  output logic        o_Flash_Clk,
  output logic        o_Flash_nCS,
  inout  wire  [3:0]  io_Flash_IO
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lim_c;
  logic             ncs_q, ncs_d;
  logic             sel_c, rd_req_c;
  logic             step_c, last_c;
  logic             active_c, load_c, capture_c, oe0_d, oe_hi_d;
  logic             sck;
  logic [31:0]      word;
  logic [3:0]       io_out, io_oe;
  logic             unused_inputs;

  assign sel_c    = (i_AV_Addr[29 -: NUM_PERIPH_SEL_BITS] ==
                     NUM_PERIPH_SEL_BITS'(PERIPH_SEL_VAL));
  assign rd_req_c = sel_c && i_AV_Read;
  // Writes are acknowledged without stalling and have no effect
  assign unused_inputs = ^{i_AV_ByteEn, i_AV_Write, i_AV_WriteData, i_AV_Addr};

  always_ff @(posedge i_Clk or negedge i_nReset) begin
    if (!i_nReset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ncs_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ncs_q   <= ncs_d;
    end
  end

  // Phase counters step once per SCK period, or per sys cycle in CS_HIGH
  always_comb begin
    lim_c = '0;
    case (state_q)
      CMD:     lim_c = CNT_W'(CMD_BITS - 1);
      ADDR:    lim_c = CNT_W'(ADDR_BITS - 1);
      DUMMY:   lim_c = CNT_W'(DUMMY_CYCLES - 1);
      DATA:    lim_c = CNT_W'(DATA_NIBBLES - 1);
      CS_HIGH: lim_c = CNT_W'(CS_HIGH_CYCLES - 1);
      default: lim_c = '0;
    endcase
    step_c  = (state_q == CS_HIGH) || (in_xfer(state_q) && sck);
    last_c  = step_c && (cnt_q == lim_c);
    state_d = state_q;
    cnt_d   = step_c ? (last_c ? '0 : cnt_q + CNT_W'(1)) : cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rd_req_c) state_d = CMD;
      end
      CMD:     if (last_c) state_d = ADDR;
      ADDR:    if (last_c) state_d = DUMMY;
      DUMMY:   if (last_c) state_d = DATA;
      DATA:    if (last_c) state_d = DONE;
      DONE: begin
        state_d = CS_HIGH;
        cnt_d   = '0;
      end
      CS_HIGH: if (last_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // IO2/IO3 come back only in CS_HIGH so they never overlap the flash driving them
  always_comb begin
    ncs_d            = ~in_xfer(state_d);
    oe0_d            = (state_d == CMD) || (state_d == ADDR);
    oe_hi_d          = !((state_d == DUMMY) || (state_d == DATA) || (state_d == DONE));
    active_c         = in_xfer(state_q);
    load_c           = (state_q == IDLE) && rd_req_c;
    capture_c        = (state_q == DATA);
    o_AV_WaitRequest = rd_req_c && (state_q != DONE);
    o_AV_ReadData    = ((state_q == DONE) && rd_req_c) ? word : '0;
  end

  qspi_shift_engine u_engine (
    .clk_i      (i_Clk),
    .rst_ni     (i_nReset),
    .active_i   (active_c),
    .load_i     (load_c),
    .load_val_i ({READ_CMD, i_AV_Addr[21:0], 2'b00}),
    .capture_i  (capture_c),
    .oe0_d_i    (oe0_d),
    .oe_hi_d_i  (oe_hi_d),
    .io_i       (io_Flash_IO),
    .sck_o      (sck),
    .io_out_o   (io_out),
    .io_oe_o    (io_oe),
    .word_o     (word)
  );

  for (genvar g = 0; g < 4; g++) begin : g_io
    assign io_Flash_IO[g] = io_oe[g] ? io_out[g] : 1'bz;
  end

  assign o_Flash_Clk = sck;
  assign o_Flash_nCS = ncs_q;

endmodule

// File: tb/tb_av_qspi_flash_reader.sv
// Randomized bench for av_qspi_flash_reader with a behavioural QSPI flash and
// a word-level reference model.
module tb_av_qspi_flash_reader;

  localparam int unsigned DUMMY   = 8;
  localparam int unsigned CS_HIGH = 2;
  localparam int unsigned RISES   = 8 + 24 + DUMMY + 8;
  localparam int unsigned LAT     = 1 + 2 * RISES;

  logic        i_Clk = 1'b0;
  logic        i_nReset = 1'b0;
  logic [29:0] i_AV_Addr = '0;
  logic [3:0]  i_AV_ByteEn = '0;
  logic        i_AV_Read = 1'b0;
  logic        i_AV_Write = 1'b0;
  logic [31:0] i_AV_WriteData = '0;
  logic [31:0] o_AV_ReadData;
  logic        o_AV_WaitRequest;
  logic        o_Flash_Clk;
  logic        o_Flash_nCS;
  wire  [3:0]  flash_io;

  int n_checks = 0;
  int n_errors = 0;

  av_qspi_flash_reader #(
    .NUM_PERIPH_SEL_BITS (1),
    .PERIPH_SEL_VAL      (0),
    .READ_CMD            (8'h6B),
    .DUMMY_CYCLES        (DUMMY),
    .CS_HIGH_CYCLES      (CS_HIGH)
  ) dut (
    .i_Clk            (i_Clk),
    .i_nReset         (i_nReset),
    .i_AV_Addr        (i_AV_Addr),
    .i_AV_ByteEn      (i_AV_ByteEn),
    .i_AV_Read        (i_AV_Read),
    .i_AV_Write       (i_AV_Write),
    .o_AV_ReadData    (o_AV_ReadData),
    .i_AV_WriteData   (i_AV_WriteData),
    .o_AV_WaitRequest (o_AV_WaitRequest),
    .o_Flash_Clk      (o_Flash_Clk),
    .o_Flash_nCS      (o_Flash_nCS),
    .io_Flash_IO      (flash_io)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Flash contents: a few fixed bytes, otherwise a hash of the address
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    case (a)
      24'h000010: return 8'h11;
      24'h000011: return 8'h22;
      24'h000012: return 8'h33;
      24'h000013: return 8'h44;
      default:    return 8'(a[7:0] * 8'd29) ^ a[15:8] ^ a[23:16] ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [31:0] ref_word(input logic [29:0] wa);
    logic [23:0] ba;
    ba = {wa[21:0], 2'b00};
    return {flash_byte(ba + 24'd3), flash_byte(ba + 24'd2),
            flash_byte(ba + 24'd1), flash_byte(ba)};
  endfunction

  // ---------------- behavioural flash ----------------
  logic [3:0]  fl_oe = '0;
  logic [3:0]  fl_dat = '0;
  logic [7:0]  fl_cmd = '0;
  logic [23:0] fl_addr = '0;
  int unsigned fl_rise = 0;
  int unsigned fl_last_rises = 0;
  int unsigned fl_n = 0;
  logic [7:0]  fl_b;

  for (genvar g = 0; g < 4; g++) begin : g_fl
    assign flash_io[g] = fl_oe[g] ? fl_dat[g] : 1'bz;
  end

  always @(negedge o_Flash_nCS) begin
    fl_rise = 0;
    fl_cmd  = '0;
    fl_addr = '0;
  end

  always @(posedge o_Flash_nCS) begin
    fl_last_rises = fl_rise;
    fl_oe = '0;
  end

  always @(posedge o_Flash_Clk) begin
    if (!o_Flash_nCS) begin
      fl_rise++;
      if (fl_rise <= 8) fl_cmd = {fl_cmd[6:0], flash_io[0]};
      else if (fl_rise <= 32) fl_addr = {fl_addr[22:0], flash_io[0]};
    end
  end

  // Mode 0: data changes after SCK falls, high nibble first
  always @(negedge o_Flash_Clk) begin
    if (!o_Flash_nCS && fl_rise >= 32 + DUMMY) begin
      fl_n = fl_rise - (32 + DUMMY);
      #1;
      if (!o_Flash_nCS) begin
        fl_b   = flash_byte(fl_addr + 24'(fl_n / 2));
        fl_dat = (fl_n % 2 == 0) ? fl_b[7:4] : fl_b[3:0];
        fl_oe  = 4'hF;
      end
    end
  end

  // ---------------- protocol monitor ----------------
  int   viol_sck = 0, viol_cs = 0, viol_io = 0;
  int   hi_run = 0, min_gap = 1000;
  bit   seen_low = 0;
  logic prev_ncs = 1'b1, prev_sck = 1'b0;

  always @(negedge i_Clk) begin
    if (!o_Flash_nCS && !prev_ncs && (o_Flash_Clk == prev_sck)) viol_sck++;
    if ((o_Flash_nCS != prev_ncs) && o_Flash_Clk) viol_cs++;
    for (int b = 0; b < 4; b++)
      if (fl_oe[b] && (flash_io[b] !== fl_dat[b])) viol_io++;
    if (o_Flash_nCS) hi_run++;
    else begin
      if (prev_ncs && seen_low && hi_run < min_gap) min_gap = hi_run;
      hi_run = 0;
      seen_low = 1;
    end
    prev_ncs = o_Flash_nCS;
    prev_sck = o_Flash_Clk;
  end

  // ---------------- bus tasks ----------------
  task automatic bus_read(input logic [29:0] addr, input bit chg_addr,
                          output logic [31:0] word, output int wc, output int stray);
    @(posedge i_Clk); #1;
    i_AV_Addr   = addr;
    i_AV_Read   = 1'b1;
    i_AV_Write  = 1'b0;
    i_AV_ByteEn = 4'($urandom);
    wc = 0;
    stray = 0;
    word = '0;
    forever begin
      @(negedge i_Clk);
      if (!o_AV_WaitRequest) break;
      if (o_AV_ReadData != 0) stray++;
      wc++;
      if (chg_addr && wc == 20) i_AV_Addr = {1'b0, 29'($urandom)};
      if (wc > 1000) break;
    end
    word = o_AV_ReadData;
  endtask

  task automatic bus_idle(input int n);
    @(posedge i_Clk); #1;
    i_AV_Read  = 1'b0;
    i_AV_Write = 1'b0;
    repeat (n) @(posedge i_Clk);
  endtask

  task automatic probe_release(input string tag);
    fl_oe  = 4'b0011;
    fl_dat = 4'b0001;
    #1 check_eq({tag, "_io10_a"}, 32'(flash_io[1:0]), 32'h1);
    fl_dat = 4'b0010;
    #1 check_eq({tag, "_io10_b"}, 32'(flash_io[1:0]), 32'h2);
    fl_oe  = '0;
    fl_dat = '0;
    check_eq({tag, "_io32"}, 32'(flash_io[3:2]), 32'h3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic [29:0] a;
    int          wc, stray, bad;
    bit          chg;

    // Reset state
    #12;
    check_eq("rst_ncs", 32'(o_Flash_nCS), 32'h1);
    check_eq("rst_sck", 32'(o_Flash_Clk), 32'h0);
    probe_release("rst");
    @(negedge i_Clk);
    i_nReset = 1'b1;
    @(negedge i_Clk);
    check_eq("rst_wait", 32'(o_AV_WaitRequest), 32'h0);
    check_eq("rst_rdata", o_AV_ReadData, 32'h0);

    // Single read of the known word
    bus_read(30'h0000_0004, 1'b0, got, wc, stray);
    check_eq("single_word", got, 32'h4433_2211);
    check_eq("single_lat", 32'(wc), 32'(LAT));
    check_eq("single_stray", 32'(stray), 32'h0);
    bus_idle(4);
    check_eq("single_cmd", 32'(fl_cmd), 32'h6B);
    check_eq("single_addr", 32'(fl_addr), 32'h10);
    check_eq("single_rises", 32'(fl_last_rises), 32'(RISES));

    // Unselected read
    @(posedge i_Clk); #1;
    i_AV_Addr = {1'b1, 29'($urandom)};
    i_AV_Read = 1'b1;
    @(negedge i_Clk);
    check_eq("unsel_wait", 32'(o_AV_WaitRequest), 32'h0);
    bad = 0;
    repeat (6) begin
      @(negedge i_Clk);
      if (o_AV_WaitRequest || o_AV_ReadData != 0 || !o_Flash_nCS) bad++;
    end
    check_eq("unsel_quiet", 32'(bad), 32'h0);
    bus_idle(2);

    // Selected write
    @(posedge i_Clk); #1;
    i_AV_Addr      = 30'h0000_0100;
    i_AV_Write     = 1'b1;
    i_AV_WriteData = 32'hDEAD_BEEF;
    @(negedge i_Clk);
    check_eq("write_wait", 32'(o_AV_WaitRequest), 32'h0);
    bad = 0;
    repeat (6) begin
      @(negedge i_Clk);
      if (o_AV_WaitRequest || o_Flash_Clk || !o_Flash_nCS) bad++;
    end
    check_eq("write_quiet", 32'(bad), 32'h0);
    bus_idle(2);

    // Back-to-back reads of consecutive words
    min_gap = 1000;
    a = {1'b0, 29'($urandom)};
    bus_read(a, 1'b0, got, wc, stray);
    check_eq("b2b_word0", got, ref_word(a));
    bus_read(a + 30'd1, 1'b0, got, wc, stray);
    check_eq("b2b_word1", got, ref_word(a + 30'd1));
    check_eq("b2b_lat1", 32'(wc), 32'(LAT + CS_HIGH));
    check_eq("b2b_stray", 32'(stray), 32'h0);
    check_eq("b2b_gap_ok", 32'(min_gap >= CS_HIGH), 32'h1);
    bus_idle(4);

    // Randomized reads, some with the address changed mid-transaction
    for (int i = 0; i < 8; i++) begin
      a   = {1'b0, 29'($urandom)};
      chg = ($urandom_range(0, 2) == 0);
      bus_read(a, chg, got, wc, stray);
      check_eq("rand_word", got, ref_word(a));
      check_eq("rand_lat", 32'(wc), 32'(LAT));
      bus_idle(3 + $urandom_range(0, 4));
    end

    // Read dropped mid-transaction: flash cycle completes, no data presented
    @(posedge i_Clk); #1;
    i_AV_Addr = 30'h0000_0040;
    i_AV_Read = 1'b1;
    repeat (30) @(posedge i_Clk);
    #1 i_AV_Read = 1'b0;
    bad = 0;
    wc = 0;
    while (o_Flash_nCS == 1'b0 && wc < 400) begin
      @(negedge i_Clk);
      if (o_AV_ReadData != 0 || o_AV_WaitRequest) bad++;
      wc++;
    end
    check_eq("drop_done", 32'(wc < 400), 32'h1);
    check_eq("drop_quiet", 32'(bad), 32'h0);
    check_eq("drop_rises", 32'(fl_last_rises), 32'(RISES));
    bus_idle(4);

    // Reset asserted in the data phase
    @(posedge i_Clk); #1;
    i_AV_Addr = 30'h0000_0004;
    i_AV_Read = 1'b1;
    repeat (86) @(negedge i_Clk);
    #2 i_nReset = 1'b0;
    #1;
    check_eq("rstmid_ncs", 32'(o_Flash_nCS), 32'h1);
    check_eq("rstmid_sck", 32'(o_Flash_Clk), 32'h0);
    #1 probe_release("rstmid");
    i_AV_Read = 1'b0;
    @(negedge i_Clk);
    i_nReset = 1'b1;
    @(negedge i_Clk);
    check_eq("rstmid_wait", 32'(o_AV_WaitRequest), 32'h0);
    check_eq("rstmid_rdata", o_AV_ReadData, 32'h0);
    bus_read(30'h0000_0004, 1'b0, got, wc, stray);
    check_eq("post_rst_word", got, 32'h4433_2211);
    bus_idle(4);

    check_eq("proto_sck_period", 32'(viol_sck), 32'h0);
    check_eq("proto_cs_edge", 32'(viol_cs), 32'h0);
    check_eq("proto_io_contention", 32'(viol_io), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
